// File: rtl/inst_fetch32.sv
// Instruction fetch front end: fetch PC, combinational imem access and a
// 2-entry FIFO prefetch buffer drained by decode through valid/ready.
module inst_fetch32 #(
  parameter int unsigned     N         = 32,
  parameter logic [N-1:0]    RESET_PC  = '0,
  parameter int unsigned     ADDR_STEP = 4
) (
  input  logic         clk,
  input  logic         rst,
  output logic [N-1:0] imem_addr,
  input  logic [N-1:0] imem_inst,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_pc,
  output logic [N-1:0] out_inst,
  input  logic         redirect_valid,
  input  logic [N-1:0] redirect_pc,
  output logic [1:0]   buf_level
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } level_t;

  localparam logic [N-1:0] STEP  = N'(ADDR_STEP);
  localparam logic [N-1:0] ALIGN = ~(STEP - N'(1));

  level_t       level, level_n;
  logic [N-1:0] fetch_pc, fetch_pc_n;
  logic [N-1:0] head_pc, head_pc_n, head_inst, head_inst_n;
  logic [N-1:0] tail_pc, tail_pc_n, tail_inst, tail_inst_n;
  logic         pop, push;

  assign imem_addr = fetch_pc;
  assign out_valid = (level != EMPTY);
  assign out_pc    = head_pc;
  assign out_inst  = head_inst;
  assign buf_level = level;

  assign pop  = (level != EMPTY) & out_ready;
  assign push = ~redirect_valid & ((level != FULL) | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      level     <= EMPTY;
      fetch_pc  <= RESET_PC;
      head_pc   <= '0;
      head_inst <= '0;
      tail_pc   <= '0;
      tail_inst <= '0;
    end else begin
      level     <= level_n;
      fetch_pc  <= fetch_pc_n;
      head_pc   <= head_pc_n;
      head_inst <= head_inst_n;
      tail_pc   <= tail_pc_n;
      tail_inst <= tail_inst_n;
    end
  end

  always_comb begin
    level_n     = level;
    fetch_pc_n  = fetch_pc;
    head_pc_n   = head_pc;
    head_inst_n = head_inst;
    tail_pc_n   = tail_pc;
    tail_inst_n = tail_inst;
    if (redirect_valid) begin
      // Flush only drops the level; stale head values stay visible but invalid.
      level_n    = EMPTY;
      fetch_pc_n = redirect_pc & ALIGN;
    end else begin
      if (push) fetch_pc_n = fetch_pc + STEP;
      unique case (level)
        EMPTY: begin
          if (push) begin
            head_pc_n   = fetch_pc;
            head_inst_n = imem_inst;
            level_n     = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_pc_n   = fetch_pc;
            head_inst_n = imem_inst;
          end else if (push) begin
            tail_pc_n   = fetch_pc;
            tail_inst_n = imem_inst;
            level_n     = FULL;
          end else if (pop) begin
            level_n = EMPTY;
          end
        end
        FULL: begin
          // At full, a pop always coincides with a push, so the level holds.
          if (pop) begin
            head_pc_n   = tail_pc;
            head_inst_n = tail_inst;
            tail_pc_n   = fetch_pc;
            tail_inst_n = imem_inst;
          end
        end
        default: level_n = EMPTY;
      endcase
    end
  end

endmodule
